// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that accepts one wide word at a time from NUM_REQ requesters
// and streams it out as SIZE_IN/SIZE_OUT narrow beats with valid/ready handshaking.
module serializer_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SIZE_IN       = 32,
  parameter int SIZE_OUT      = 8,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*SIZE_IN-1:0]   req_data,
  input  logic                         output_ready,
  output logic                         output_valid,
  output logic [SIZE_OUT-1:0]          data_out,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         last_beat
);

  localparam int BEATS = SIZE_IN / SIZE_OUT;
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if (NUM_REQ < 2 || (SIZE_IN % SIZE_OUT) != 0 || BEATS < 2) begin : g_bad_params
      $error("serializer_arbiter: need NUM_REQ>=2 and SIZE_IN a multiple (>=2x) of SIZE_OUT");
    end
  endgenerate

  typedef enum logic {IDLE, SERIAL} state_e;

  state_e               state_q, state_d;
  logic [SIZE_IN-1:0]   word_q, word_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      winner, cand;
  logic [CNT_W-1:0]     sel;
  logic                 any_valid, load_en, beat_acc, word_hs;

  // Scan downward so the candidate closest to ptr_q+1 is the last (winning) write.
  always_comb begin
    winner    = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (word_hs) state_d = SERIAL;
      SERIAL:  if (beat_acc && last_beat) state_d = word_hs ? SERIAL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    output_valid = (state_q == SERIAL) && !reset;
    last_beat    = output_valid && (cnt_q == LAST_CNT);
    beat_acc     = output_valid && output_ready;
    load_en      = !reset && ((state_q == IDLE) || (beat_acc && last_beat));
    word_hs      = load_en && any_valid;
    req_ready    = '0;
    if (word_hs) req_ready[winner] = 1'b1;
  end

  always_comb begin
    word_d  = word_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (word_hs) begin
      word_d  = req_data[winner*SIZE_IN +: SIZE_IN];
      grant_d = winner;
      ptr_d   = winner;
      cnt_d   = '0;
    end else if (beat_acc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign sel      = (LITTLE_ENDIAN != 0) ? cnt_q : (LAST_CNT - cnt_q);
  assign data_out = word_q[sel*SIZE_OUT +: SIZE_OUT];
  assign grant_id = grant_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Scoreboarded bench: two DUTs (LSB-first and MSB-first) share stimulus; a forked
// monitor compares every presented beat against the expected-beat queues.
module tb_serializer_arbiter;
  localparam int NR = 4;
  localparam int SI = 32;
  localparam int SO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     rdy_le, rdy_be;
  logic [NR*SI-1:0]  req_data;
  logic              output_ready;
  logic              ov_le, ov_be, lb_le, lb_be;
  logic [SO-1:0]     do_le, do_be;
  logic [1:0]        gid_le, gid_be;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t q_le[$];
  beat_t q_be[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    pops_le = 0;
  int    p0;

  always #5 clk = ~clk;

  serializer_arbiter #(.NUM_REQ(NR), .SIZE_IN(SI), .SIZE_OUT(SO), .LITTLE_ENDIAN(1)) u_le (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_le), .req_data(req_data),
    .output_ready(output_ready), .output_valid(ov_le), .data_out(do_le), .grant_id(gid_le),
    .last_beat(lb_le));

  serializer_arbiter #(.NUM_REQ(NR), .SIZE_IN(SI), .SIZE_OUT(SO), .LITTLE_ENDIAN(0)) u_be (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_be), .req_data(req_data),
    .output_ready(output_ready), .output_valid(ov_be), .data_out(do_be), .grant_id(gid_be),
    .last_beat(lb_be));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [1:0] g, input logic [31:0] w, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.g = g;
      b.l = (k == 3);
      b.d = w[k*8 +: 8];
      q_le.push_back(b);
      b.d = w[(3-k)*8 +: 8];
      q_be.push_back(b);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] w);
    req_data[i*SI +: SI] = w;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && ov_le) begin
        if (q_le.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL le_extra_beat: got data 0x%0h grant %0d, expected no beat", do_le, gid_le);
        end else begin
          chk("le_data", 32'(do_le), 32'(q_le[0].d));
          chk("le_grant", 32'(gid_le), 32'(q_le[0].g));
          chk("le_last", 32'(lb_le), 32'(q_le[0].l));
          if (output_ready) begin
            void'(q_le.pop_front());
            pops_le++;
          end
        end
      end
      if (!reset && ov_be) begin
        if (q_be.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL be_extra_beat: got data 0x%0h grant %0d, expected no beat", do_be, gid_be);
        end else begin
          chk("be_data", 32'(do_be), 32'(q_be[0].d));
          chk("be_grant", 32'(gid_be), 32'(q_be[0].g));
          chk("be_last", 32'(lb_be), 32'(q_be[0].l));
          if (output_ready) void'(q_be.pop_front());
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state, with requests pending to prove req_ready is held low
    reset = 1'b1; req_valid = 4'hF; req_data = '0; output_ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(ov_le), 0);
    chk("rst_last", 32'(lb_le), 0);
    chk("rst_grant", 32'(gid_le), 0);
    chk("rst_ready_le", 32'(rdy_le), 0);
    chk("rst_ready_be", 32'(rdy_be), 0);
    reset = 1'b0; req_valid = '0;
    tick(1);

    // Single word from requester 1, both beat orders
    set_req(1, 32'hAABBCCDD); req_valid = 4'b0010;
    push_word(2'd1, 32'hAABBCCDD, 4);
    #1 chk("rr_first_ready", 32'(rdy_le), 32'h2);
    tick(1);
    req_valid = '0;
    chk("lat1_valid", 32'(ov_le), 1);
    chk("lat1_le_beat", 32'(do_le), 32'hDD);
    chk("lat1_be_beat", 32'(do_be), 32'hAA);
    chk("lat1_grant", 32'(gid_le), 1);
    tick(4);
    chk("w1_idle", 32'(ov_le), 0);
    chk("w1_drained", q_le.size(), 0);

    // Fresh reset, all requesters valid: grants 0,1,2,3,0 back to back
    reset = 1'b1; tick(2); reset = 1'b0;
    set_req(0, 32'h0F1E2D3C); set_req(1, 32'h4B5A6978);
    set_req(2, 32'h8796A5B4); set_req(3, 32'hC3D2E1F0);
    req_valid = 4'hF;
    push_word(2'd0, 32'h0F1E2D3C, 4); push_word(2'd1, 32'h4B5A6978, 4);
    push_word(2'd2, 32'h8796A5B4, 4); push_word(2'd3, 32'hC3D2E1F0, 4);
    push_word(2'd0, 32'h0F1E2D3C, 4);
    p0 = pops_le;
    tick(17);
    req_valid = '0;
    tick(4);
    chk("rr_beats_no_bubble", pops_le - p0, 20);
    chk("rr_idle", 32'(ov_le), 0);

    // Grant 3, then 0 and 2 requested mid-word: no mid-word grant, wrap to 0, then 2
    set_req(3, 32'h55667788); req_valid = 4'b1000;
    push_word(2'd3, 32'h55667788, 4);
    tick(1);
    req_valid = '0;
    tick(1);
    set_req(0, 32'h99AABBCC); set_req(2, 32'hDDEEFF00); req_valid = 4'b0101;
    push_word(2'd0, 32'h99AABBCC, 4); push_word(2'd2, 32'hDDEEFF00, 4);
    #1 chk("no_midword_ready", 32'(rdy_le), 0);
    tick(3);
    req_valid = 4'b0100;
    tick(4);
    req_valid = '0;
    tick(4);
    chk("wrap_idle", 32'(ov_le), 0);
    chk("wrap_drained", q_le.size(), 0);

    // Backpressure: hold CC for 3 cycles
    set_req(1, 32'hAABBCCDD); req_valid = 4'b0010;
    push_word(2'd1, 32'hAABBCCDD, 4);
    tick(1);
    req_valid = '0;
    tick(1);
    output_ready = 1'b0;
    #1 chk("stall_cc_start", 32'(do_le), 32'hCC);
    tick(3);
    chk("stall_cc_end", 32'(do_le), 32'hCC);
    chk("stall_valid", 32'(ov_le), 1);
    output_ready = 1'b1;
    tick(3);
    chk("stall_idle", 32'(ov_le), 0);
    chk("stall_drained", q_le.size(), 0);

    // Reset after CC is accepted: remaining beats discarded, pointer back to 0
    set_req(0, 32'hAABBCCDD); req_valid = 4'b0001;
    push_word(2'd0, 32'hAABBCCDD, 2);
    tick(1);
    req_valid = '0;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_valid", 32'(ov_le), 0);
    chk("mid_rst_grant", 32'(gid_le), 0);
    chk("mid_rst_ready", 32'(rdy_le), 0);
    set_req(1, 32'h01020304); set_req(3, 32'h0A0B0C0D); req_valid = 4'b1010;
    push_word(2'd1, 32'h01020304, 4); push_word(2'd3, 32'h0A0B0C0D, 4);
    reset = 1'b0;
    #1 chk("post_rst_ready", 32'(rdy_le), 32'h2);
    tick(1);
    req_valid = 4'b1000;
    tick(4);
    req_valid = '0;
    tick(4);
    chk("post_rst_idle", 32'(ov_le), 0);
    chk("final_le_drained", q_le.size(), 0);
    chk("final_be_drained", q_be.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
